// File: rtl/jt51_pkg.sv
// Shared constants and payload types for the JT51 serial DAC output path.
package jt51_pkg;

  localparam int unsigned FRAME_SLOTS = 32;
  localparam int unsigned WORD_SLOTS  = 16;
  localparam int unsigned PAD_BITS    = 3;
  localparam int unsigned MANT_BITS   = 10;
  localparam int unsigned EXP_BITS    = 3;
  localparam int unsigned SAMPLE_W    = 16;
  localparam int unsigned CNT_W       = $clog2(FRAME_SLOTS);

  // One serial word; bit 0 is the first slot sent.
  typedef struct packed {
    logic [EXP_BITS-1:0]  e;
    logic [MANT_BITS-1:0] m;
    logic [PAD_BITS-1:0]  pad;
  } word_t;

  // Left word occupies the low slots of the frame.
  typedef struct packed {
    word_t right;
    word_t left;
  } frame_t;

endpackage

// File: rtl/jt51_ser_out_if.sv
// Sample input and serial DAC output bundle of jt51_ser_out.
interface jt51_ser_out_if;
  import jt51_pkg::*;

  logic                cen;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] left_in;
  logic [SAMPLE_W-1:0] right_in;
  logic                so;
  logic                sh1;
  logic                sh2;
  logic                overrun;

  modport master (
    output cen, sample_valid, left_in, right_in,
    input  so, sh1, sh2, overrun
  );

  modport slave (
    input  cen, sample_valid, left_in, right_in,
    output so, sh1, sh2, overrun
  );

endinterface

// File: rtl/jt51_fp_enc.sv
// Combinational 16-bit signed to 10-bit mantissa / 3-bit exponent float encoder.
module jt51_fp_enc
  import jt51_pkg::*;
(
  input  logic [SAMPLE_W-1:0]  x_i,
  output logic [MANT_BITS-1:0] m_o,
  output logic [EXP_BITS-1:0]  e_o
);

  // eq[i] set when bit i matches the sign bit
  logic [14:9] eq;

  assign eq = ~(x_i[14:9] ^ {6{x_i[15]}});

  always_comb begin
    e_o = 3'd7;
    if      (&eq[14:9])  e_o = 3'd1;
    else if (&eq[14:10]) e_o = 3'd2;
    else if (&eq[14:11]) e_o = 3'd3;
    else if (&eq[14:12]) e_o = 3'd4;
    else if (&eq[14:13]) e_o = 3'd5;
    else if (eq[14])     e_o = 3'd6;
    m_o = MANT_BITS'(x_i >> (e_o - 3'd1));
  end

endmodule

// File: rtl/jt51_ser_out.sv
// Serialises encoded left/right samples into a 32-slot frame with sample-hold strobes.
module jt51_ser_out
  import jt51_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  jt51_ser_out_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(FRAME_SLOTS - 1);
  localparam logic [CNT_W-1:0] SH1_SLOT  = CNT_W'(WORD_SLOTS - 1);

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pend_q, pend_d;
  logic [SAMPLE_W-1:0]    pl_q, pl_d, pr_q, pr_d;
  logic [FRAME_SLOTS-1:0] sr_q, sr_d;
  logic                   so_q, so_d;
  logic                   sh1_q, sh1_d;
  logic                   sh2_q, sh2_d;
  logic                   ovr_q, ovr_d;

  logic                   wrap_c;
  logic [SAMPLE_W-1:0]    enc_l_c, enc_r_c;
  logic [MANT_BITS-1:0]   m_l_c, m_r_c;
  logic [EXP_BITS-1:0]    e_l_c, e_r_c;
  frame_t                 frame_c;

  assign wrap_c = (cnt_q == LAST_SLOT);

  // A strobe on the wrap edge bypasses the pending registers
  assign enc_l_c = bus.sample_valid ? bus.left_in  : pl_q;
  assign enc_r_c = bus.sample_valid ? bus.right_in : pr_q;

  jt51_fp_enc u_enc_l (.x_i(enc_l_c), .m_o(m_l_c), .e_o(e_l_c));
  jt51_fp_enc u_enc_r (.x_i(enc_r_c), .m_o(m_r_c), .e_o(e_r_c));

  always_comb begin
    frame_c         = '0;
    frame_c.left.m  = m_l_c;
    frame_c.left.e  = e_l_c;
    frame_c.right.m = m_r_c;
    frame_c.right.e = e_r_c;
  end

  // Rotating the frame re-sends the last pair when nothing new is loaded
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    pl_d   = pl_q;
    pr_d   = pr_q;
    sr_d   = sr_q;
    ovr_d  = ovr_q;
    if (bus.cen) begin
      cnt_d = cnt_q + CNT_W'(1);
      ovr_d = 1'b0;
      sr_d  = {sr_q[0], sr_q[FRAME_SLOTS-1:1]};
      if (wrap_c) begin
        if (bus.sample_valid || pend_q) sr_d = frame_c;
        pend_d = 1'b0;
      end else if (bus.sample_valid) begin
        pl_d   = bus.left_in;
        pr_d   = bus.right_in;
        pend_d = 1'b1;
        ovr_d  = pend_q;
      end
    end
    so_d  = sr_d[0];
    sh1_d = (cnt_d == SH1_SLOT);
    sh2_d = (cnt_d == LAST_SLOT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
      pl_q   <= '0;
      pr_q   <= '0;
      sr_q   <= '0;
      so_q   <= 1'b0;
      sh1_q  <= 1'b0;
      sh2_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      pl_q   <= pl_d;
      pr_q   <= pr_d;
      sr_q   <= sr_d;
      so_q   <= so_d;
      sh1_q  <= sh1_d;
      sh2_q  <= sh2_d;
      ovr_q  <= ovr_d;
    end
  end

  assign bus.so      = so_q;
  assign bus.sh1     = sh1_q;
  assign bus.sh2     = sh2_q;
  assign bus.overrun = ovr_q;

endmodule
